regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Owns the register file's single write port (we3/A3/wd3) and shares it between two writers.
//  Port A is core writeback: highest priority, no backpressure. Port B is a long-latency unit
//  (load/div), valid/ready, buffered in a DEPTH-entry FIFO.
//  Also sequences a post-reset zero sweep of the file and flags RAW hazards on queued B writes.
// PARAMETERS
//  NREGS      32  registers swept in INIT (addresses 0..NREGS-1)
//  DEPTH      2   B-side FIFO entries (power of 2, >=2)
//  STARVE_MAX 8   cycles a FIFO head may wait before stall_req asserts
//  SWEEP_EN   1   1: run INIT sweep after reset; 0: enter RUN directly
// PORTS
//  clk        in   1   clock, all state on posedge
//  clr        in   1   reset, synchronous, active-high
//  a_we       in   1   core writeback enable
//  a_addr     in   5   core writeback register
//  a_data     in   32  core writeback data
//  b_valid    in   1   B write request
//  b_ready    out  1   B request accepted this cycle when b_valid&b_ready
//  b_addr     in   5   B destination register
//  b_data     in   32  B data
//  rs1_addr   in   5   core read address 1 (hazard check)
//  rs2_addr   in   5   core read address 2 (hazard check)
//  rf_we3     out  1   to register file we3
//  rf_a3      out  5   to register file A3
//  rf_wd3     out  32  to register file wd3
//  raw_stall  out  1   rs1/rs2 matches a queued B write
//  stall_req  out  1   core must hold a_we low while high
//  init_busy  out  1   INIT sweep in progress
//  a_drop_err out  1   sticky: a_we seen during INIT or while stall_req high
// BEHAVIOUR
//  - Reset (clr=1 at posedge): state=INIT (SWEEP_EN=1) else RUN, sweep ctr=0, FIFO emptied,
//    age=0, a_drop_err=0. While clr=1: rf_we3=0, b_ready=0, raw_stall=0, stall_req=0,
//    init_busy=1. Reset mid-operation discards all queued B writes; no partial write issued.
//  - FSM INIT: rf_we3=1, rf_a3=ctr, rf_wd3=0; ctr++ each cycle; after NREGS cycles -> RUN.
//    b_ready=0 in INIT. a_we in INIT is not written and sets a_drop_err.
//  - FSM RUN: outputs combinational, so the write lands on the same posedge (zero latency).
//    - a_we=1 and a_addr!=0: rf_we3=1, rf_a3=a_addr, rf_wd3=a_data; FIFO head not dequeued.
//    - Otherwise FIFO non-empty: head written (rf_we3=1 unless head addr==0), head dequeued.
//    - a_addr==0 or head addr==0: rf_we3 stays 0; an x0 head is still dequeued.
//  - Ordering: a_we with a_addr!=0 invalidates every valid FIFO entry with the same addr that
//    cycle. Killed entries are dequeued later without a write, so newer core data is never
//    overwritten by older B data.
//  - b_ready = RUN & !full (a same-cycle dequeue does not free a slot for that cycle).
//    Enqueue when b_valid&b_ready, at the tail in arrival order. b_addr==0 is accepted.
//  - raw_stall = RUN & any valid entry with addr!=0 matching rs1_addr or rs2_addr.
//    An entry written this cycle still counts.
//  - age: counts cycles the head is valid but not written; reset to 0 on dequeue or empty.
//    stall_req = (age >= STARVE_MAX). a_we while stall_req=1: not written, sets a_drop_err.
//    Head is then written that cycle.
//  - Full and empty FIFO pointers wrap modulo DEPTH; simultaneous enq+deq keeps count.
// TESTING
//  1 clr 1 cycle, SWEEP_EN=1 -> rf_we3=1 for 32 cycles, rf_a3=0..31, wd3=0; init_busy falls
//    on cycle 33.
//  2 RUN, a_we=1 a_addr=5 a_data=0xDEADBEEF, b_valid=1 b_addr=6 -> rf_a3=5 same cycle;
//    next idle cycle rf_a3=6 rf_wd3=b_data.
//  3 Enqueue B addr=7 data=1, then a_we addr=7 data=2 -> rf writes 7<=2 only.
//    FIFO drains with no write of 1.
//  4 Fill DEPTH=2 while a_we busy -> b_ready=0. rs1_addr=queued addr -> raw_stall=1.
//    After drain -> raw_stall=0, b_ready=1.
//  5 a_we every cycle with FIFO non-empty -> stall_req=1 after 8 cycles.
//    Head written that cycle; a_we during it sets a_drop_err.
//  6 clr mid-drain with 2 queued -> no further B writes; b_ready=0 through INIT.
//    a_we/b_addr=0 cases never assert rf_we3.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Owns the single write port (we3/A3/wd3) of the register file and shares it
// between two writers:
//   - port A: core writeback. Highest priority, no backpressure.
//   - port B: a long-latency unit (load/div). Uses a valid/ready handshake and
//     is buffered in a small DEPTH-entry FIFO.
// After reset the block can also sweep zeros into every register (INIT state).
// It also flags read-after-write hazards against B writes that are still queued.
//
// Parameters
//   NREGS      registers cleared by the INIT sweep (addresses 0..NREGS-1)
//   DEPTH      B-side FIFO entries (power of two, at least 2)
//   STARVE_MAX cycles a FIFO head may be passed over before stall_req rises
//   SWEEP_EN   1: run the INIT sweep after reset, 0: go straight to RUN
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   clr        in   synchronous active-high reset
//   a_we       in   core writeback enable
//   a_addr     in   core writeback destination register
//   a_data     in   core writeback data
//   b_valid    in   B write request
//   b_ready    out  B request is accepted when b_valid & b_ready
//   b_addr     in   B destination register
//   b_data     in   B write data
//   rs1_addr   in   core read address 1, used for the hazard check
//   rs2_addr   in   core read address 2, used for the hazard check
//   rf_we3     out  register file write enable
//   rf_a3      out  register file write address
//   rf_wd3     out  register file write data
//   raw_stall  out  rs1/rs2 matches a live queued B write
//   stall_req  out  core must hold a_we low while this is high
//   init_busy  out  INIT sweep in progress (also high while clr is held)
//   a_drop_err out  sticky flag: an a_we was ignored (during INIT or a stall)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int NREGS      = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8,
  parameter int SWEEP_EN   = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        a_we,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rf_we3,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        raw_stall,
  output logic        stall_req,
  output logic        init_busy,
  output logic        a_drop_err
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]   sweep_ctr;
  logic            sweep_done;

  // Each FIFO slot stores its destination and data. occ marks slots holding
  // a request. kill marks requests that newer core data has overtaken.
  logic [4:0]      fifo_addr [DEPTH];
  logic [31:0]     fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_occ;
  logic [DEPTH-1:0] fifo_kill;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;

  logic [AW-1:0]   age;

  logic            run;
  logic            in_init;
  logic            fifo_empty;
  logic            fifo_full;
  logic [4:0]      head_addr;
  logic [31:0]     head_data;
  logic            head_kill;
  logic            stall_int;
  logic            a_win;
  logic            deq;
  logic            enq;
  logic            ready_int;
  logic            hazard_hit;

  // Qualifiers for the current cycle. A held clr overrides the state
  // register, so every qualifier is gated with it. No request is accepted,
  // written or flagged while clr is high.
  always_comb begin
    run        = (state_q == ST_RUN) && !clr;
    in_init    = (state_q == ST_INIT) && !clr;
    fifo_empty = (count == '0);
    fifo_full  = (count == CNTW'(DEPTH));
    head_addr  = fifo_addr[rd_ptr];
    head_data  = fifo_data[rd_ptr];
    head_kill  = fifo_kill[rd_ptr];
    sweep_done = (sweep_ctr == CW'(NREGS - 1));
  end

  // Arbitration. A starved head (stall_int) takes the port away from the
  // core for one cycle. Otherwise a core write to a real register wins.
  // A core write aimed at x0 has no effect, so in that cycle the FIFO head
  // may use the port. The slot freed by a dequeue stays unavailable to B
  // until the next cycle, which keeps b_ready independent of port A.
  always_comb begin
    stall_int = run && (age >= AW'(STARVE_MAX));
    a_win     = run && a_we && (a_addr != '0) && !stall_int;
    deq       = run && !fifo_empty && !a_win;
    ready_int = run && !fifo_full;
    enq       = b_valid && ready_int;
  end

  // Hazard detection covers every live queued write, including the head
  // that is draining this cycle. Its value is not in the file until the
  // next edge. Entries killed by a newer core write and x0 entries never
  // produce a value, so neither can cause a hazard.
  always_comb begin
    hazard_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_occ[i] && !fifo_kill[i] && (fifo_addr[i] != '0) &&
          ((fifo_addr[i] == rs1_addr) || (fifo_addr[i] == rs2_addr))) begin
        hazard_hit = 1'b1;
      end
    end
  end

  // State register of the INIT/RUN controller. Reset picks the start state
  // from SWEEP_EN, so a design with the sweep disabled accepts traffic
  // right after clr drops.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= (SWEEP_EN != 0) ? ST_INIT : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and register-file port drive. The outputs are combinational
  // from the state and the current inputs, so the selected write lands on
  // the next rising edge with no added latency. In INIT the sweep owns the
  // port and writes zero to the address in sweep_ctr.
  always_comb begin
    state_d = state_q;
    rf_we3  = 1'b0;
    rf_a3   = '0;
    rf_wd3  = '0;
    if (!clr) begin
      if (state_q == ST_INIT) begin
        rf_we3 = 1'b1;
        rf_a3  = 5'(sweep_ctr);
        rf_wd3 = '0;
        if (sweep_done) begin
          state_d = ST_RUN;
        end
      end else begin
        if (a_win) begin
          rf_we3 = 1'b1;
          rf_a3  = a_addr;
          rf_wd3 = a_data;
        end else if (deq) begin
          rf_we3 = !head_kill && (head_addr != '0);
          rf_a3  = head_addr;
          rf_wd3 = head_data;
        end
      end
    end
  end

  // Sweep address counter. It only advances while INIT owns the port and
  // restarts from zero on every reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      sweep_ctr <= '0;
    end else if (in_init) begin
      sweep_ctr <= sweep_ctr + CW'(1);
    end
  end

  // FIFO bookkeeping: pointers, occupancy and kill bits. A core write
  // marks every queued request to the same register as dead. That entry
  // later drains without a write, so older B data can never overwrite
  // newer core data. The slot being filled this cycle is never occupied,
  // so the kill loop and the enqueue never fight over the same bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_occ  <= '0;
      fifo_kill <= '0;
    end else begin
      if (a_win) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_occ[i] && (fifo_addr[i] == a_addr)) begin
            fifo_kill[i] <= 1'b1;
          end
        end
      end
      if (enq) begin
        fifo_occ[wr_ptr]  <= 1'b1;
        fifo_kill[wr_ptr] <= 1'b0;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (deq) begin
        fifo_occ[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (enq && !deq) begin
        count <= count + CNTW'(1);
      end else if (deq && !enq) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // FIFO payload storage. It needs no reset because occupancy alone
  // decides whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= b_addr;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // Starvation age of the current head. It counts cycles in which a
  // request waits at the head while the core holds the port, and clears
  // whenever the head drains or the queue is empty. Reaching STARVE_MAX
  // forces a dequeue in that same cycle, so the counter never exceeds it.
  always_ff @(posedge clk) begin
    if (clr) begin
      age <= '0;
    end else if (!run || fifo_empty || deq) begin
      age <= '0;
    end else begin
      age <= age + AW'(1);
    end
  end

  // Sticky error for core writes the block had to ignore: any a_we during
  // the sweep, or while the core was told to stall. Only clr clears it.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_drop_err <= 1'b0;
    end else if (a_we && (in_init || stall_int)) begin
      a_drop_err <= 1'b1;
    end
  end

  // Status outputs. init_busy stays high during clr, so the core sees a
  // busy register file from the moment reset starts.
  always_comb begin
    b_ready   = ready_int;
    stall_req = stall_int;
    raw_stall = run && hazard_hit;
    init_busy = clr || (state_q == ST_INIT);
  end

endmodule
